ni_target_resp_header: RTL and testbench

Response-header generator for xpipes target NIs, the return-path counterpart of the initiator-side address-to-route LUT. It records the source initiator ID and transaction ID of every accepted request in an outstanding FIFO. When the attached target core produces a response, it pops the oldest entry and looks up the return route from the source ID. It then presents a registered 80-bit response header flit to the NI packetizer with valid/ready handshaking.

---
 rtl/noc_parameters.sv | 24 ++
 rtl/routing_target_resp.sv | 28 ++
 rtl/ni_target_resp_header.sv | 130 +++++++++++++
 tb/tb_ni_target_resp_header.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/noc_parameters.sv
// Shared NoC parameters for the noc18_4sw_80bits topology.
// Holds flit/field widths, response-header field offsets and the
// encodings of the target response-header FSM.
package noc_parameters;

  localparam int FLIT_W = 80;
  localparam int PATH_W = 7;
  localparam int ID_W   = 4;
  localparam int TID_W  = 4;

  // Response header field offsets
  localparam int PATH_LSB = 0;
  localparam int DEST_LSB = 7;
  localparam int SRC_LSB  = 11;
  localparam int TID_LSB  = 15;
  localparam int ERR_BIT  = 19;
  localparam int RSP_BIT  = 20;

  typedef enum logic {
    IDLE = 1'b0,
    HDR  = 1'b1
  } state_t;

endpackage

// File: rtl/routing_target_resp.sv
// Return-route table for this target NI (topology noc18_4sw_80bits).
// Combinational: source initiator ID -> return path (first hop in LSBs)
// plus a failed-decoding flag for IDs with no route.
//   i_src    : source initiator ID of the head request
//   o_path   : return path
//   o_failed : 1 when i_src has no route
module routing_target_resp #(
  parameter int ID_W   = 4,
  parameter int PATH_W = 7
) (
  input  logic [ID_W-1:0]   i_src,
  output logic [PATH_W-1:0] o_path,
  output logic              o_failed
);

  always_comb begin
    o_path   = '0;
    o_failed = 1'b0;
    case (i_src)
      ID_W'(4'h3): o_path = PATH_W'(7'b0000000);
      ID_W'(4'h6): o_path = PATH_W'(7'b0000001);
      ID_W'(4'h9): o_path = PATH_W'(7'b0000011);
      ID_W'(4'ha): o_path = PATH_W'(7'b0000110);
      default:     o_failed = 1'b1;
    endcase
  end

endmodule

// File: rtl/ni_target_resp_header.sv
// Target-NI response-header generator.
// Each accepted request pushes {source ID, tid} into an outstanding FIFO.
// A core response pops the oldest entry, looks up the return route and
// registers a response header flit presented with valid/ready.
//   i_clock, i_reset          : clock, synchronous active-high reset
//   i_req_valid/o_req_ready   : request capture (i_req_source, i_req_tid)
//   i_rsp_valid/o_rsp_ready   : response from target core (i_rsp_err)
//   o_hdr_valid/i_hdr_ready   : header flit handshake (o_hdr_flit)
//   o_route_error             : one-cycle pulse on an unroutable source ID
//   o_outstanding             : FIFO occupancy, 0..DEPTH
module ni_target_resp_header #(
  parameter int               DEPTH  = 4,
  parameter int               FLIT_W = noc_parameters::FLIT_W,
  parameter int               PATH_W = noc_parameters::PATH_W,
  parameter int               ID_W   = noc_parameters::ID_W,
  parameter int               TID_W  = noc_parameters::TID_W,
  parameter logic [ID_W-1:0]  MY_ID  = ID_W'(4'h1)
) (
  input  logic                       i_clock,
  input  logic                       i_reset,
  input  logic                       i_req_valid,
  output logic                       o_req_ready,
  input  logic [ID_W-1:0]            i_req_source,
  input  logic [TID_W-1:0]           i_req_tid,
  input  logic                       i_rsp_valid,
  output logic                       o_rsp_ready,
  input  logic                       i_rsp_err,
  output logic                       o_hdr_valid,
  input  logic                       i_hdr_ready,
  output logic [FLIT_W-1:0]          o_hdr_flit,
  output logic                       o_route_error,
  output logic [$clog2(DEPTH):0]     o_outstanding
);

  import noc_parameters::*;

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DEPTH-1:0][ID_W-1:0]  r_src;
  logic [DEPTH-1:0][TID_W-1:0] r_tid;
  logic [AW-1:0]               r_wptr, r_rptr;
  logic [CW-1:0]               r_count;
  state_t                      r_state, w_state_nxt;
  logic [FLIT_W-1:0]           r_hdr_flit;
  logic                        r_route_error;

  logic                        w_full, w_empty, w_push, w_pop;
  logic [ID_W-1:0]             w_head_src;
  logic [TID_W-1:0]            w_head_tid;
  logic [PATH_W-1:0]           w_path;
  logic                        w_failed;
  logic [FLIT_W-1:0]           w_hdr;

  assign w_full     = (r_count == CW'(DEPTH));
  assign w_empty    = (r_count == '0);
  assign w_head_src = r_src[r_rptr];
  assign w_head_tid = r_tid[r_rptr];

  // Push is gated only by full: a pop in the same cycle does not free a slot.
  assign o_req_ready = !w_full;
  assign w_push      = i_req_valid && !w_full;
  assign o_rsp_ready = (r_state == IDLE) && !w_empty;
  assign w_pop       = i_rsp_valid && o_rsp_ready;

  routing_target_resp #(.ID_W(ID_W), .PATH_W(PATH_W)) u_route (
    .i_src    (w_head_src),
    .o_path   (w_path),
    .o_failed (w_failed)
  );

  always_comb begin
    w_hdr                        = '0;
    w_hdr[PATH_LSB +: PATH_W]    = w_path;
    w_hdr[DEST_LSB +: ID_W]      = w_head_src;
    w_hdr[SRC_LSB  +: ID_W]      = MY_ID;
    w_hdr[TID_LSB  +: TID_W]     = w_head_tid;
    w_hdr[ERR_BIT]               = i_rsp_err;
    w_hdr[RSP_BIT]               = 1'b1;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: if (w_pop && !w_failed) w_state_nxt = HDR;
      HDR:  if (i_hdr_ready)        w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state       <= IDLE;
      r_wptr        <= '0;
      r_rptr        <= '0;
      r_count       <= '0;
      r_hdr_flit    <= '0;
      r_route_error <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_route_error <= w_pop && w_failed;
      if (w_pop && !w_failed) r_hdr_flit <= w_hdr;
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage needs no reset; occupancy is tracked by r_count.
  always_ff @(posedge i_clock) begin
    if (w_push) begin
      r_src[r_wptr] <= i_req_source;
      r_tid[r_wptr] <= i_req_tid;
    end
  end

  assign o_hdr_valid   = (r_state == HDR);
  assign o_hdr_flit    = r_hdr_flit;
  assign o_route_error = r_route_error;
  assign o_outstanding = r_count;

  // A response with nothing outstanding is a target-core protocol violation.
  a_rsp_no_outstanding: assert property (@(posedge i_clock) disable iff (i_reset)
    !(i_rsp_valid && w_empty && (r_state == IDLE)));

endmodule

// File: tb/tb_ni_target_resp_header.sv
module tb_ni_target_resp_header;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready;
  logic [3:0]  req_source, req_tid;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic        hdr_valid, hdr_ready;
  logic [79:0] hdr_flit;
  logic        route_error;
  logic [2:0]  outstanding;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  ni_target_resp_header dut (
    .i_clock       (clk),
    .i_reset       (rst),
    .i_req_valid   (req_valid),
    .o_req_ready   (req_ready),
    .i_req_source  (req_source),
    .i_req_tid     (req_tid),
    .i_rsp_valid   (rsp_valid),
    .o_rsp_ready   (rsp_ready),
    .i_rsp_err     (rsp_err),
    .o_hdr_valid   (hdr_valid),
    .i_hdr_ready   (hdr_ready),
    .o_hdr_flit    (hdr_flit),
    .o_route_error (route_error),
    .o_outstanding (outstanding)
  );

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [3:0] src, input logic [3:0] tid);
    req_valid = 1'b1; req_source = src; req_tid = tid;
    tick();
    req_valid = 1'b0;
  endtask

  logic [79:0] exp_flit;
  logic [79:0] ordered [3];

  initial begin
    rst = 1'b1; req_valid = 0; req_source = 0; req_tid = 0;
    rsp_valid = 0; rsp_err = 0; hdr_ready = 0;
    tick(); tick();
    chk("rst_outstanding", 80'(outstanding), 80'd0);
    chk("rst_req_ready",   80'(req_ready),   80'd1);
    chk("rst_rsp_ready",   80'(rsp_ready),   80'd0);
    chk("rst_hdr_valid",   80'(hdr_valid),   80'd0);
    chk("rst_hdr_flit",    hdr_flit,         80'd0);
    chk("rst_route_error", 80'(route_error), 80'd0);
    rst = 1'b0;

    // Basic request/response
    push(4'h6, 4'h2);
    chk("t1_outstanding", 80'(outstanding), 80'd1);
    chk("t1_rsp_ready",   80'(rsp_ready),   80'd1);
    rsp_valid = 1; rsp_err = 0;
    tick();
    rsp_valid = 0;
    chk("t1_hdr_valid", 80'(hdr_valid), 80'd1);
    chk("t1_hdr_flit",  hdr_flit, 80'({1'b1, 1'b0, 4'h2, 4'h1, 4'h6, 7'b0000001}));
    chk("t1_flit_hex",  hdr_flit, 80'h110B01);
    chk("t1_outst_after", 80'(outstanding), 80'd0);
    chk("t1_rsp_ready_hdr", 80'(rsp_ready), 80'd0);
    hdr_ready = 1;
    tick();
    hdr_ready = 0;
    chk("t1_hdr_done", 80'(hdr_valid), 80'd0);

    // Fill, then refused push in pop cycle
    for (int i = 0; i < 4; i++) push(4'h3, 4'(i));
    chk("full_outstanding", 80'(outstanding), 80'd4);
    chk("full_req_ready",   80'(req_ready),   80'd0);
    req_valid = 1; req_source = 4'h9; req_tid = 4'h5;
    rsp_valid = 1;
    tick();
    rsp_valid = 0;
    chk("nobypass_outst", 80'(outstanding), 80'd3);
    chk("nobypass_ready", 80'(req_ready),   80'd1);
    chk("fill_hdr_flit",  hdr_flit, 80'({1'b1, 1'b0, 4'h0, 4'h1, 4'h3, 7'b0000000}));
    tick();
    req_valid = 0;
    chk("late_push_outst", 80'(outstanding), 80'd4);
    hdr_ready = 1;
    tick();
    hdr_ready = 0;
    // Move into HDR with 3 entries left, then reset
    rsp_valid = 1;
    tick();
    rsp_valid = 0;
    chk("pre_rst_hdr_valid", 80'(hdr_valid),   80'd1);
    chk("pre_rst_outst",     80'(outstanding), 80'd3);
    rst = 1;
    tick();
    rst = 0;
    chk("hdr_rst_valid", 80'(hdr_valid),   80'd0);
    chk("hdr_rst_outst", 80'(outstanding), 80'd0);
    chk("hdr_rst_ready", 80'(req_ready),   80'd1);

    // Route miss
    push(4'h7, 4'h4);
    rsp_valid = 1;
    tick();
    rsp_valid = 0;
    chk("miss_route_error", 80'(route_error), 80'd1);
    chk("miss_hdr_valid",   80'(hdr_valid),   80'd0);
    chk("miss_outst",       80'(outstanding), 80'd0);
    tick();
    chk("miss_pulse_end",   80'(route_error), 80'd0);
    chk("miss_hdr_valid2",  80'(hdr_valid),   80'd0);

    // Back-pressure stall
    push(4'ha, 4'h7);
    push(4'h9, 4'h8);
    rsp_valid = 1; rsp_err = 1;
    tick();
    exp_flit = 80'({1'b1, 1'b1, 4'h7, 4'h1, 4'ha, 7'b0000110});
    for (int i = 0; i < 5; i++) begin
      chk("stall_flit",      hdr_flit,            exp_flit);
      chk("stall_hdr_valid", 80'(hdr_valid),      80'd1);
      chk("stall_rsp_ready", 80'(rsp_ready),      80'd0);
      tick();
    end
    hdr_ready = 1;
    tick();
    hdr_ready = 0;
    chk("release_idle",      80'(hdr_valid), 80'd0);
    chk("release_rsp_ready", 80'(rsp_ready), 80'd1);
    tick();
    rsp_valid = 0; rsp_err = 0;
    chk("second_hdr_valid", 80'(hdr_valid), 80'd1);
    chk("second_hdr_flit",  hdr_flit, 80'({1'b1, 1'b1, 4'h8, 4'h1, 4'h9, 7'b0000011}));
    hdr_ready = 1;
    tick();
    hdr_ready = 0;

    // Ordering across three responses
    push(4'h3, 4'h1);
    push(4'h9, 4'h2);
    push(4'ha, 4'h3);
    ordered[0] = 80'({1'b1, 1'b0, 4'h1, 4'h1, 4'h3, 7'b0000000});
    ordered[1] = 80'({1'b1, 1'b0, 4'h2, 4'h1, 4'h9, 7'b0000011});
    ordered[2] = 80'({1'b1, 1'b0, 4'h3, 4'h1, 4'ha, 7'b0000110});
    for (int i = 0; i < 3; i++) begin
      rsp_valid = 1;
      tick();
      rsp_valid = 0;
      chk("order_valid", 80'(hdr_valid), 80'd1);
      chk("order_flit",  hdr_flit,       ordered[i]);
      hdr_ready = 1;
      tick();
      hdr_ready = 0;
    end
    chk("order_outst", 80'(outstanding), 80'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
